// File: rtl/filter_decim_fifo_if.sv
// Sample-stream and sink handshake bundle for filter_decim_fifo.
// The design drives the outputs through the slave modport.
interface filter_decim_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]      i_data;
  logic                   i_valid;
  logic [DATA_W-1:0]      o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [$clog2(DEPTH):0] o_level;
  logic [CNT_W-1:0]       o_overflow_cnt;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid, o_level, o_overflow_cnt
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid, o_level, o_overflow_cnt
  );
endinterface

// File: rtl/filter_decim_fifo.sv
// Decimates the filter sample stream by DECIM and buffers kept samples in a
// DEPTH-entry FIFO with a saturating drop counter for overflow.
module filter_decim_fifo #(
  parameter int DATA_W = 8,
  parameter int DECIM  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  filter_decim_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

  occ_t              state, next_state;
  logic [PW-1:0]     phase;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  drop_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              keep, push, pop, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Decimation and FIFO control decisions for this cycle
  always_comb begin
    keep       = bus.i_valid && (phase == PW'(DECIM - 1));
    pop        = (state != EMPTY) && bus.i_ready;
    push       = keep && ((state != FULL) || pop);
    drop       = keep && !push;
    next_state = state;
    case (state)
      EMPTY:   if (push) next_state = PARTIAL;
      PARTIAL: begin
        if (push && !pop && level == LW'(DEPTH - 1))
          next_state = FULL;
        else if (pop && !push && level == LW'(1))
          next_state = EMPTY;
      end
      FULL:    if (pop && !push) next_state = PARTIAL;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      state <= next_state;
      if (bus.i_valid)
        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Storage is data-only: no reset, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.i_data;
  end

  assign bus.o_valid        = (state != EMPTY);
  assign bus.o_data         = (state != EMPTY) ? mem[rd_ptr] : '0;
  assign bus.o_level        = level;
  assign bus.o_overflow_cnt = drop_cnt;

endmodule

// File: tb/tb_filter_decim_fifo.sv
// Bench for filter_decim_fifo: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_filter_decim_fifo;
  localparam int DECIM = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  filter_decim_fifo_if #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) if0 ();
  filter_decim_fifo_if #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2)) if1 ();

  assign if1.i_data  = if0.i_data;
  assign if1.i_valid = if0.i_valid;
  assign if1.i_ready = if0.i_ready;

  filter_decim_fifo #(.DATA_W(8), .DECIM(DECIM), .DEPTH(DEPTH), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  filter_decim_fifo #(.DATA_W(8), .DECIM(DECIM), .DEPTH(DEPTH), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    int         ev;
    int         ed;
    int         el;
    int         ec;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_fail = 0;

  int q[$];
  int mph = 0;
  int drops = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    q.delete();
    mph = 0;
    drops = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit r);
    bit pop, keep, push;
    pop  = (q.size() > 0) && r;
    keep = v && (mph == DECIM - 1);
    if (v) mph = (mph + 1) % DECIM;
    push = keep && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    else if (keep) drops++;
  endtask

  // Called at a falling edge: apply inputs, step model at the rising edge,
  // return at the next falling edge ready for sampling.
  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    if0.i_valid = v;
    if0.i_data  = d;
    if0.i_ready = r;
    @(posedge clk);
    model_step(v, int'(d), r);
    @(negedge clk);
  endtask

  task automatic check_model();
    cmp("m_valid", int'(if0.o_valid), int'(q.size() > 0));
    cmp("m_data", int'(if0.o_data), (q.size() > 0) ? q[0] : 0);
    cmp("m_level", int'(if0.o_level), q.size());
    cmp("m_cnt8", int'(if0.o_overflow_cnt), sat(drops, 255));
    cmp("m_cnt2", int'(if1.o_overflow_cnt), sat(drops, 3));
    cmp("m_level2", int'(if1.o_level), q.size());
    cmp("m_data2", int'(if1.o_data), (q.size() > 0) ? q[0] : 0);
  endtask

  task automatic add(input bit v, input int d, input bit r,
                     input int ev, input int ed, input int el, input int ec);
    vec_t t;
    t.v = v; t.d = 8'(d); t.r = r; t.ev = ev; t.ed = ed; t.el = el; t.ec = ec;
    tbl.push_back(t);
  endtask

  initial begin
    if0.i_valid = 1'b0;
    if0.i_data  = '0;
    if0.i_ready = 1'b0;

    // Decimation with sink always ready
    add(1,10,1, 0,0,0,0);  add(1,11,1, 1,11,1,0);
    add(1,12,1, 0,0,0,0);  add(1,13,1, 1,13,1,0);
    add(0,0,1,  0,0,0,0);
    // Fill to full, two drops, then drain
    add(1,8'hEE,0, 0,0,0,0); add(1,1,0, 1,1,1,0);
    add(1,8'hEE,0, 1,1,1,0); add(1,2,0, 1,1,2,0);
    add(1,8'hEE,0, 1,1,2,0); add(1,3,0, 1,1,3,0);
    add(1,8'hEE,0, 1,1,3,0); add(1,4,0, 1,1,4,0);
    add(1,8'hEE,0, 1,1,4,0); add(1,5,0, 1,1,4,1);
    add(1,8'hEE,0, 1,1,4,1); add(1,6,0, 1,1,4,2);
    add(0,0,1, 1,2,3,2); add(0,0,1, 1,3,2,2);
    add(0,0,1, 1,4,1,2); add(0,0,1, 0,0,0,2);
    // Full, then simultaneous push of 9 and pop
    add(1,8'hEE,0, 0,0,0,2); add(1,1,0, 1,1,1,2);
    add(1,8'hEE,0, 1,1,1,2); add(1,2,0, 1,1,2,2);
    add(1,8'hEE,0, 1,1,2,2); add(1,3,0, 1,1,3,2);
    add(1,8'hEE,0, 1,1,3,2); add(1,4,0, 1,1,4,2);
    add(1,8'hEE,0, 1,1,4,2); add(1,9,1, 1,2,4,2);
    add(0,0,1, 1,3,3,2); add(0,0,1, 1,4,2,2);
    add(0,0,1, 1,9,1,2); add(0,0,1, 0,0,0,2);

    @(negedge clk);
    cmp("rst_valid", int'(if0.o_valid), 0);
    cmp("rst_data", int'(if0.o_data), 0);
    cmp("rst_level", int'(if0.o_level), 0);
    cmp("rst_cnt", int'(if0.o_overflow_cnt), 0);
    reset = 1'b0;
    model_clear();

    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].r);
      cmp($sformatf("tbl%0d_valid", i), int'(if0.o_valid), tbl[i].ev);
      cmp($sformatf("tbl%0d_data", i), int'(if0.o_data), tbl[i].ed);
      cmp($sformatf("tbl%0d_level", i), int'(if0.o_level), tbl[i].el);
      cmp($sformatf("tbl%0d_cnt", i), int'(if0.o_overflow_cnt), tbl[i].ec);
    end

    // Backpressure: two stall cycles then one pop
    tick(1,8'hEE,0); tick(1,7,0); tick(1,8'hEE,0); tick(1,8,0);
    cmp("bp_level", int'(if0.o_level), 2);
    tick(0,0,0);
    cmp("bp_stall1_data", int'(if0.o_data), 7);
    cmp("bp_stall1_level", int'(if0.o_level), 2);
    tick(0,0,0);
    cmp("bp_stall2_data", int'(if0.o_data), 7);
    cmp("bp_stall2_level", int'(if0.o_level), 2);
    tick(0,0,1);
    cmp("bp_pop_data", int'(if0.o_data), 8);
    cmp("bp_pop_level", int'(if0.o_level), 1);
    tick(0,0,1);
    check_model();

    // Reset mid-stream with level 3 and phase 1
    tick(1,8'hEE,0); tick(1,30,0); tick(1,8'hEE,0); tick(1,31,0);
    tick(1,8'hEE,0); tick(1,32,0); tick(1,8'hEE,0);
    cmp("mid_level", int'(if0.o_level), 3);
    if0.i_valid = 1'b0;
    if0.i_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    cmp("arst_valid", int'(if0.o_valid), 0);
    cmp("arst_level", int'(if0.o_level), 0);
    cmp("arst_data", int'(if0.o_data), 0);
    cmp("arst_cnt", int'(if0.o_overflow_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    tick(1,20,0);
    cmp("post_rst_1st_level", int'(if0.o_level), 0);
    cmp("post_rst_1st_valid", int'(if0.o_valid), 0);
    tick(1,21,0);
    cmp("post_rst_2nd_level", int'(if0.o_level), 1);
    cmp("post_rst_2nd_data", int'(if0.o_data), 21);
    tick(0,0,1);

    // Counter saturation: 4 stored, 8 dropped
    for (int i = 0; i < 24; i++) tick(1, 8'(i + 40), 0);
    cmp("sat_cnt2", int'(if1.o_overflow_cnt), 3);
    cmp("sat_cnt8", int'(if0.o_overflow_cnt), 8);
    check_model();
    for (int i = 0; i < 5; i++) tick(0,0,1);
    check_model();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 4));
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
